// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
//   Steps an N-input combinational block through all 2^N input rows, holds
//   each row for SETTLE cycles, captures the block's output into a truth
//   table word and compares it against an expected table latched at start.
//
// Parameters
//   N_INPUTS  number of function inputs (2..6)
//   SETTLE    cycles each row is held before sampling (1..255)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request a sweep (accepted only when idle)
//   abort      cancel an in-progress sweep (honoured only while waiting)
//   fn_out     output of the block under evaluation
//   expected   expected truth table, bit r = output for row r
//   fn_in      block input vector, value r = row r (MSB = inp1)
//   busy       high while a sweep is in progress
//   done       one-cycle completion pulse
//   table_out  captured truth table, bit r = sampled fn_out for row r
//   mismatch   table_out ^ latched expected, filled in as rows are sampled
//   err_count  number of mismatching rows sampled so far
//   pass       completed sweep with zero mismatches
// ---------------------------------------------------------------------------

// Per-row capture cell: owns one bit of table_out and mismatch.
module tts_row_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,       // sweep accepted: forget previous results
    input  logic hit,       // this row is being sampled on this edge
    input  logic fn_out,
    input  logic exp_bit,
    output logic tbl_bit,
    output logic mis_bit
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_bit <= 1'b0;
            mis_bit <= 1'b0;
        end else if (clr) begin
            tbl_bit <= 1'b0;
            mis_bit <= 1'b0;
        end else if (hit) begin
            tbl_bit <= fn_out;
            mis_bit <= fn_out ^ exp_bit;
        end
    end
endmodule

module truth_table_sweeper #(
    parameter int N_INPUTS = 4,
    parameter int SETTLE   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       fn_out,
    input  logic [(1<<N_INPUTS)-1:0]   expected,
    output logic [N_INPUTS-1:0]        fn_in,
    output logic                       busy,
    output logic                       done,
    output logic [(1<<N_INPUTS)-1:0]   table_out,
    output logic [(1<<N_INPUTS)-1:0]   mismatch,
    output logic [N_INPUTS:0]          err_count,
    output logic                       pass
);
    localparam int ROWS = 1 << N_INPUTS;
    localparam int RW   = N_INPUTS + 1;      // one spare bit so the last-row compare never wraps
    localparam int CW   = $clog2(SETTLE + 1);
    localparam logic [RW-1:0] LAST   = RW'(ROWS - 1);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE);
    localparam logic [CW-1:0] FINAL  = CW'(1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t          state;
    logic [RW-1:0]   row;
    logic [CW-1:0]   cnt;
    logic [ROWS-1:0] expected_q;

    logic            clr;
    logic            smp;
    logic            miss;
    logic [ROWS-1:0] row_hit;

    // Sweep acceptance and the sample strobe for the current row. Abort
    // takes priority over sampling, so an aborted row is never captured.
    assign clr  = (state == IDLE) && start;
    assign smp  = (state == WAIT) && !abort && (cnt == FINAL);
    assign miss = fn_out ^ expected_q[row[N_INPUTS-1:0]];

    genvar i;
    generate
        for (i = 0; i < ROWS; i++) begin : g_row
            assign row_hit[i] = smp && (row == RW'(i));
            tts_row_cell u_cell (
                .clk     (clk),
                .rst     (rst),
                .clr     (clr),
                .hit     (row_hit[i]),
                .fn_out  (fn_out),
                .exp_bit (expected_q[i]),
                .tbl_bit (table_out[i]),
                .mis_bit (mismatch[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            cnt        <= '0;
            expected_q <= '0;
            fn_in      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            pass       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        expected_q <= expected;
                        err_count  <= '0;
                        pass       <= 1'b0;
                        row        <= '0;
                        cnt        <= RELOAD;
                        fn_in      <= '0;
                        busy       <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        // Partial results stay visible for inspection.
                        fn_in <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == FINAL) begin
                        if (miss)
                            err_count <= err_count + 1'b1;
                        if (row == LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            // Advance the row on the sample edge so fn_in
                            // only ever moves on row boundaries.
                            row   <= row + 1'b1;
                            fn_in <= fn_in + 1'b1;
                            cnt   <= RELOAD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    pass  <= (err_count == '0);
                    busy  <= 1'b0;
                    fn_in <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Instance 0: SETTLE=2, programmable function table.
    logic        start0 = 1'b0, abort0 = 1'b0, fn_out0;
    logic [15:0] exp0 = '0, ftab = '0;
    logic [3:0]  fn_in0;
    logic        busy0, done0, pass0;
    logic [15:0] tbl0, mis0;
    logic [4:0]  err0;

    // Instance 1: SETTLE=1, constant-1 function.
    logic        start1 = 1'b0, abort1 = 1'b0, fn_out1;
    logic [15:0] exp1 = '0;
    logic [3:0]  fn_in1;
    logic        busy1, done1, pass1;
    logic [15:0] tbl1, mis1;
    logic [4:0]  err1;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    assign fn_out0 = ftab[fn_in0];
    assign fn_out1 = 1'b1;

    truth_table_sweeper #(.N_INPUTS(4), .SETTLE(2)) u0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .fn_out(fn_out0),
        .expected(exp0), .fn_in(fn_in0), .busy(busy0), .done(done0),
        .table_out(tbl0), .mismatch(mis0), .err_count(err0), .pass(pass0));

    truth_table_sweeper #(.N_INPUTS(4), .SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .fn_out(fn_out1),
        .expected(exp1), .fn_in(fn_in1), .busy(busy1), .done(done1),
        .table_out(tbl1), .mismatch(mis1), .err_count(err1), .pass(pass1));

    typedef struct {
        logic [15:0] f;
        logic [15:0] e;
        logic [15:0] xt;
        logic [15:0] xm;
        int          xerr;
        logic        xp;
    } vec_t;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [15:0] msk(int n);
        logic [31:0] t;
        t = (n >= 16) ? 32'hFFFF : ((32'h1 << n) - 1);
        return t[15:0];
    endfunction

    // Model view of the outputs k cycles after the accepting edge:
    // rows 0..(k/S)-1 have been sampled, row k/S is being driven.
    function automatic logic [63:0] model(int k, int s, logic [15:0] f, logic [15:0] e);
        int          rows;
        logic [15:0] m;
        logic        b, d, p;
        logic [3:0]  fi;
        logic [4:0]  ec;
        rows = (k / s > 16) ? 16 : k / s;
        m    = msk(rows);
        b    = (k <= 16 * s);
        d    = (k == 16 * s);
        p    = (k > 16 * s) && ((f ^ e) == 16'h0);
        fi   = (k < 16 * s) ? 4'(k / s) : ((k == 16 * s) ? 4'hF : 4'h0);
        ec   = 5'($countones((f ^ e) & m));
        return {20'h0, b, d, p, fi, f & m, (f ^ e) & m, ec};
    endfunction

    function automatic logic [63:0] obs0();
        return {20'h0, busy0, done0, pass0, fn_in0, tbl0, mis0, err0};
    endfunction

    function automatic logic [63:0] obs1();
        return {20'h0, busy1, done1, pass1, fn_in1, tbl1, mis1, err1};
    endfunction

    // Full sweep on instance 0, checked every cycle against the model and
    // at the end against the record's expected final values.
    task automatic sweep0(input vec_t v, input string nm);
        ftab   = v.f;
        exp0   = v.e;
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        for (int k = 0; k <= 33; k++) begin
            if (k > 0) cyc();
            chk($sformatf("%s_k%0d", nm, k), obs0(), model(k, 2, v.f, v.e));
        end
        chk({nm, "_final"}, {11'h0, tbl0, mis0, err0, pass0},
            {11'h0, v.xt, v.xm, 5'(v.xerr), v.xp});
    endtask

    function automatic vec_t rnd_vec();
        vec_t v;
        v.f    = 16'($urandom);
        v.e    = ($urandom_range(0, 3) == 0) ? v.f : 16'($urandom);
        v.xt   = v.f;
        v.xm   = v.f ^ v.e;
        v.xerr = $countones(v.f ^ v.e);
        v.xp   = (v.f == v.e);
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[5];
        vec_t v;
        int   dcnt, dpos0, dpos1, guard;
        logic busy_gap, busy_restart;

        vt[0] = '{16'h6600, 16'h6600, 16'h6600, 16'h0000, 0,  1'b1};
        vt[1] = '{16'h6600, 16'h6601, 16'h6600, 16'h0001, 1,  1'b0};
        vt[2] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16, 1'b0};
        vt[3] = '{16'h0000, 16'hAAAA, 16'h0000, 16'hAAAA, 8,  1'b0};
        vt[4] = '{16'h8001, 16'h8001, 16'h8001, 16'h0000, 0,  1'b1};

        // Reset state
        repeat (3) cyc();
        chk("reset0", obs0(), 64'h0);
        chk("reset1", obs1(), 64'h0);
        rst = 1'b0;
        cyc();
        chk("idle0", obs0(), 64'h0);

        // Table-driven sweeps
        for (int i = 0; i < 5; i++) begin
            sweep0(vt[i], $sformatf("vec%0d", i));
            cyc();
        end

        // Randomised sweeps against the model
        for (int i = 0; i < 4; i++) begin
            sweep0(rnd_vec(), $sformatf("rnd%0d", i));
            repeat ($urandom_range(1, 3)) cyc();
        end

        // Abort at row 4: rows 0..3 kept, no done, pass cleared
        ftab   = 16'h3C5A;
        exp0   = 16'h6600;
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        for (int k = 1; k <= 9; k++) cyc();
        abort0 = 1'b1;
        cyc();
        abort0 = 1'b0;
        chk("abort_state", obs0(),
            {20'h0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h3C5A & msk(4),
             (16'h3C5A ^ 16'h6600) & msk(4), 5'($countones((16'h3C5A ^ 16'h6600) & msk(4)))});
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (done0 || busy0) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);

        // Async reset mid-sweep at row 7, then a full sweep
        ftab   = 16'h6600;
        exp0   = 16'h6600;
        start0 = 1'b1;
        cyc();
        start0 = 1'b0;
        for (int k = 1; k <= 14; k++) cyc();
        chk("pre_rst_row7", 64'(fn_in0), 64'd7);
        #3 rst = 1'b1;
        #1;
        chk("rst_async0", obs0(), 64'h0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst_idle0", obs0(), 64'h0);
        v = rnd_vec();
        sweep0(v, "post_rst");
        cyc();

        // start held for 80 cycles: two sweeps, one idle cycle between
        ftab   = 16'h6600;
        exp0   = 16'h6600;
        start0 = 1'b1;
        dcnt = 0; dpos0 = -1; dpos1 = -1;
        busy_gap = 1'b1; busy_restart = 1'b0;
        for (int k = 0; k < 80; k++) begin
            cyc();
            if (done0) begin
                if (dcnt == 0) dpos0 = k;
                else if (dcnt == 1) dpos1 = k;
                dcnt++;
            end
            if (k == 33) busy_gap = busy0;
            if (k == 34) busy_restart = busy0;
        end
        start0 = 1'b0;
        chk("held_done_count", 64'(dcnt), 64'd2);
        chk("held_done_pos0", 64'(dpos0), 64'd32);
        chk("held_done_pos1", 64'(dpos1), 64'd66);
        chk("held_idle_gap", {62'h0, busy_gap, busy_restart}, 64'h1);
        guard = 0;
        while (busy0 && guard < 200) begin
            cyc();
            guard++;
        end
        chk("held_drain", 64'(busy0), 64'd0);
        chk("held_final", {tbl0, mis0, 11'h0, err0, 15'h0, pass0},
            {16'h6600, 16'h0, 11'h0, 5'd0, 15'h0, 1'b1});

        // SETTLE=1, constant-1 function, expected all zero
        exp1   = 16'h0000;
        start1 = 1'b1;
        cyc();
        start1 = 1'b0;
        for (int k = 0; k <= 17; k++) begin
            if (k > 0) cyc();
            chk($sformatf("s1_k%0d", k), obs1(), model(k, 1, 16'hFFFF, 16'h0000));
        end
        chk("s1_final", {tbl1, mis1, 11'h0, err1, 15'h0, pass1},
            {16'hFFFF, 16'hFFFF, 11'h0, 5'd16, 15'h0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
